// File: rtl/ir_pkg.sv
// Shared constants, assembly-state encoding and width helper for the instruction fetch register.
package ir_pkg;

   localparam int DEF_BUS_W       = 8;
   localparam int DEF_INSTR_BYTES = 2;
   localparam int DEF_DEPTH       = 2;

   typedef enum logic {
      ASM_EMPTY   = 1'b0,
      ASM_PARTIAL = 1'b1
   } asm_state_t;

   // Index width for a counter covering 0..n-1, never narrower than one bit.
   function automatic int lane_cnt_w(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/instruction_fetch_register_if.sv
// Beat input, queue read and flush bundle of the instruction fetch register.
// The Overrun signal exists only when IR_OVERRUN_EN is defined.
interface instruction_fetch_register_if #(
   parameter int BUS_W       = 8,
   parameter int INSTR_BYTES = 2,
   parameter int DEPTH       = 2
);
   localparam int IR_W  = BUS_W * INSTR_BYTES;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [BUS_W-1:0] I;
   logic             IValid;
   logic             IReady;
   logic             Flush;
   logic [IR_W-1:0]  IROut;
   logic             IRValid;
   logic             Advance;
   logic [LVL_W-1:0] Level;
`ifdef IR_OVERRUN_EN
   logic             Overrun;

   modport master (
      output I, IValid, Flush, Advance,
      input  IReady, IROut, IRValid, Level, Overrun
   );

   modport slave (
      input  I, IValid, Flush, Advance,
      output IReady, IROut, IRValid, Level, Overrun
   );
`else
   modport master (
      output I, IValid, Flush, Advance,
      input  IReady, IROut, IRValid, Level
   );

   modport slave (
      input  I, IValid, Flush, Advance,
      output IReady, IROut, IRValid, Level
   );
`endif
endinterface

// File: rtl/ir_queue.sv
// Circular FIFO of assembled instructions; flush clears pointers and level, not storage.
// Head output reads as zero whenever the queue is empty.
module ir_queue
   import ir_pkg::*;
#(
   parameter int IR_W  = 16,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [IR_W-1:0]              din,
   output logic [IR_W-1:0]              dout,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int                 PTR_W    = lane_cnt_w(DEPTH);
   localparam int                 LVL_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(DEPTH);

   logic [IR_W-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r, rd_ptr_nxt_s;
   logic [PTR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
   logic [LVL_W-1:0] level_r, level_nxt_s;
   logic             push_s, pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Qualified push/pop; a full queue only accepts a push alongside a pop.
   always_comb begin
      pop_s  = pop && (level_r != {LVL_W{1'b0}}) && !flush;
      push_s = push && !flush && ((level_r != LVL_FULL) || pop_s);
   end

   // Pointer and level next-state; flush wins over push and pop.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      level_nxt_s  = level_r;
      if (flush) begin
         rd_ptr_nxt_s = {PTR_W{1'b0}};
         wr_ptr_nxt_s = {PTR_W{1'b0}};
         level_nxt_s  = {LVL_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
         endcase
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         level_r  <= level_nxt_s;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Head presentation, zero-forced while empty.
   always_comb begin
      valid = (level_r != {LVL_W{1'b0}});
      level = level_r;
      if (valid) begin
         dout = mem_r[rd_ptr_r];
      end else begin
         dout = {IR_W{1'b0}};
      end
   end

endmodule

// File: rtl/instruction_fetch_register.sv
// Byte-serial instruction register: assembles BUS_W beats into IR_W words feeding a prefetch queue.
// Optional sticky overrun flag when IR_OVERRUN_EN is defined.
module instruction_fetch_register
   import ir_pkg::*;
#(
   parameter int BUS_W       = DEF_BUS_W,
   parameter int INSTR_BYTES = DEF_INSTR_BYTES,
   parameter int DEPTH       = DEF_DEPTH
) (
   input logic                          Clock,
   input logic                          Reset_n,
   instruction_fetch_register_if.slave  bus
);
   localparam int               IR_W      = BUS_W * INSTR_BYTES;
   localparam int               LVL_W     = $clog2(DEPTH + 1);
   localparam int               CNT_W     = lane_cnt_w(INSTR_BYTES);
   localparam int               LAST_LANE = INSTR_BYTES - 1;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(INSTR_BYTES - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [IR_W-1:0]  asm_r, asm_nxt_s, push_data_s;
   asm_state_t       state_s;
   logic             last_s, ready_s, accept_s, push_s, pop_s;
   logic [IR_W-1:0]  head_s;
   logic             head_valid_s;
   logic [LVL_W-1:0] level_s;

   // Handshake: readiness depends only on Flush and registered state.
   always_comb begin
      last_s   = (cnt_r == LAST_CNT);
      ready_s  = !bus.Flush && (!last_s || (level_s != LVL_FULL));
      accept_s = bus.IValid && ready_s;
      push_s   = accept_s && last_s;
      pop_s    = bus.Advance && head_valid_s && !bus.Flush;
   end

   // Assembly FSM next-state: lane write, lane counter advance and the word handed to the queue.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      asm_nxt_s   = asm_r;
      push_data_s = asm_r;
      push_data_s[LAST_LANE*BUS_W +: BUS_W] = bus.I;
      if (cnt_r == {CNT_W{1'b0}}) begin
         state_s = ASM_EMPTY;
      end else begin
         state_s = ASM_PARTIAL;
      end
      if (bus.Flush) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (accept_s) begin
         asm_nxt_s[int'(cnt_r)*BUS_W +: BUS_W] = bus.I;
         case (state_s)
            ASM_EMPTY, ASM_PARTIAL: begin
               if (last_s) begin
                  cnt_nxt_s = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            default: cnt_nxt_s = {CNT_W{1'b0}};
         endcase
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Assembly FSM state register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_r <= {CNT_W{1'b0}};
         asm_r <= {IR_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
         asm_r <= asm_nxt_s;
      end
   end

   ir_queue #(
      .IR_W  (IR_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (Clock),
      .rst_n (Reset_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (bus.Flush),
      .din   (push_data_s),
      .dout  (head_s),
      .valid (head_valid_s),
      .level (level_s)
   );

`ifdef IR_OVERRUN_EN
   logic overrun_r;

   // Sticky flag for a beat offered while not ready; the beat itself is dropped.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         overrun_r <= 1'b0;
      end else if (bus.Flush) begin
         overrun_r <= 1'b0;
      end else if (bus.IValid && !ready_s) begin
         overrun_r <= 1'b1;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign bus.Overrun = overrun_r;
`endif

   assign bus.IReady  = ready_s;
   assign bus.IROut   = head_s;
   assign bus.IRValid = head_valid_s;
   assign bus.Level   = level_s;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Directed bench: 8x2 beats into a 2-deep queue, plus a 4-beat instance for wide assembly.
// Overrun checks are compiled in with IR_OVERRUN_EN.
module tb_instruction_fetch_register;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   instruction_fetch_register_if #(.BUS_W(8), .INSTR_BYTES(2), .DEPTH(2)) ifa ();
   instruction_fetch_register_if #(.BUS_W(8), .INSTR_BYTES(4), .DEPTH(2)) ifb ();

   instruction_fetch_register #(.BUS_W(8), .INSTR_BYTES(2), .DEPTH(2)) u_a (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (ifa.slave)
   );

   instruction_fetch_register #(.BUS_W(8), .INSTR_BYTES(4), .DEPTH(2)) u_b (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (ifb.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic [7:0] b);
      ifa.I      = b;
      ifa.IValid = 1'b1;
      tick();
      ifa.IValid = 1'b0;
   endtask

   task automatic beat_b(input logic [7:0] b);
      ifb.I      = b;
      ifb.IValid = 1'b1;
      tick();
      ifb.IValid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      ifa.I       = 8'h00;
      ifa.IValid  = 1'b0;
      ifa.Flush   = 1'b0;
      ifa.Advance = 1'b0;
      ifb.I       = 8'h00;
      ifb.IValid  = 1'b0;
      ifb.Flush   = 1'b0;
      ifb.Advance = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;

      chk("rst_irout",   32'(ifa.IROut),   32'h0);
      chk("rst_irvalid", 32'(ifa.IRValid), 32'h0);
      chk("rst_level",   32'(ifa.Level),   32'h0);
      chk("rst_iready",  32'(ifa.IReady),  32'h1);
`ifdef IR_OVERRUN_EN
      chk("rst_overrun", 32'(ifa.Overrun), 32'h0);
`endif
      tick();

      // Wide instance: four beats, least-significant lane first.
      beat_b(8'h01);
      beat_b(8'h02);
      beat_b(8'h03);
      chk("b_partial_level", 32'(ifb.Level), 32'h0);
      beat_b(8'h04);
      chk("b_irout", 32'(ifb.IROut), 32'h04030201);
      chk("b_level", 32'(ifb.Level), 32'h1);

      // Basic assembly.
      beat_a(8'h34);
      chk("a_half_irvalid", 32'(ifa.IRValid), 32'h0);
      chk("a_half_iready",  32'(ifa.IReady),  32'h1);
      beat_a(8'h12);
      chk("a_irout_1234",  32'(ifa.IROut),   32'h1234);
      chk("a_irvalid_1",   32'(ifa.IRValid), 32'h1);
      chk("a_level_1",     32'(ifa.Level),   32'h1);

      // Fill the queue, then a partial word that cannot complete.
      beat_a(8'h78);
      beat_a(8'h56);
      chk("full_level", 32'(ifa.Level), 32'h2);
      chk("full_head",  32'(ifa.IROut), 32'h1234);
      beat_a(8'h9A);
      chk("full_cnt1_iready", 32'(ifa.IReady), 32'h0);
      ifa.I      = 8'hBC;
      ifa.IValid = 1'b1;
      tick();
      chk("held_level",  32'(ifa.Level),  32'h2);
      chk("held_iready", 32'(ifa.IReady), 32'h0);
`ifdef IR_OVERRUN_EN
      chk("overrun_set", 32'(ifa.Overrun), 32'h1);
`endif
      ifa.Advance = 1'b1;
      tick();
      ifa.Advance = 1'b0;
      chk("adv_head_5678", 32'(ifa.IROut),  32'h5678);
      chk("adv_level_1",   32'(ifa.Level),  32'h1);
      chk("adv_iready",    32'(ifa.IReady), 32'h1);
      tick();
      ifa.IValid = 1'b0;
      chk("bc9a_level_2", 32'(ifa.Level), 32'h2);
      chk("bc9a_head",    32'(ifa.IROut), 32'h5678);
      ifa.Advance = 1'b1;
      tick();
      ifa.Advance = 1'b0;
      chk("head_bc9a", 32'(ifa.IROut), 32'hBC9A);
      chk("level_bc9a", 32'(ifa.Level), 32'h1);
`ifdef IR_OVERRUN_EN
      chk("overrun_sticky", 32'(ifa.Overrun), 32'h1);
`endif

      // Push and pop on the same edge.
      beat_a(8'h11);
      ifa.Advance = 1'b1;
      beat_a(8'h22);
      ifa.Advance = 1'b0;
      chk("pushpop_level", 32'(ifa.Level), 32'h1);
      chk("pushpop_head",  32'(ifa.IROut), 32'h2211);

      // Flush with a queued word and a partial word pending.
      beat_a(8'hAA);
      ifa.Flush  = 1'b1;
      ifa.I      = 8'h55;
      ifa.IValid = 1'b1;
      #1;
      chk("flush_iready", 32'(ifa.IReady), 32'h0);
      tick();
      ifa.Flush  = 1'b0;
      ifa.IValid = 1'b0;
      chk("flush_level",   32'(ifa.Level),   32'h0);
      chk("flush_irvalid", 32'(ifa.IRValid), 32'h0);
      chk("flush_irout",   32'(ifa.IROut),   32'h0);
`ifdef IR_OVERRUN_EN
      chk("flush_overrun", 32'(ifa.Overrun), 32'h0);
`endif
      beat_a(8'h66);
      beat_a(8'h77);
      chk("post_flush_head",  32'(ifa.IROut), 32'h7766);
      chk("post_flush_level", 32'(ifa.Level), 32'h1);

      // Asynchronous reset in the middle of an instruction.
      beat_a(8'h34);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_irout",   32'(ifa.IROut),   32'h0);
      chk("midrst_irvalid", 32'(ifa.IRValid), 32'h0);
      chk("midrst_level",   32'(ifa.Level),   32'h0);
      chk("midrst_iready",  32'(ifa.IReady),  32'h1);
      #1;
      rst_n = 1'b1;
      beat_a(8'h01);
      beat_a(8'h02);
      chk("after_rst_head", 32'(ifa.IROut), 32'h0201);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_register.md
# instruction_fetch_register

Parametrised, byte-serial instruction register with a small prefetch queue. It accepts instruction bytes from the memory/bus side one per handshake and assembles them into full-width instruction words. Completed words are held in a DEPTH-entry FIFO, which the control unit reads and retires one at a time. It replaces the fixed 16-bit, manually half-selected register: byte-lane sequencing is automatic, and fetch runs ahead of decode.

## Interface
- BUS_W, 8, width of one fetched byte/beat (≥1)
- INSTR_BYTES, 2, beats per instruction (≥1); IR_W = BUS_W*INSTR_BYTES
- DEPTH, 2, assembled-instruction queue entries (≥1)

- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- I  in  BUS_W  incoming instruction beat
- IValid  in  1  I carries a valid beat
- IReady  out  1  beat is accepted on this edge when IValid && IReady
- Flush  in  1  synchronous discard of queue and partial instruction
- IROut  out  IR_W  head-of-queue instruction
- IRValid  out  1  IROut holds a valid instruction
- Advance  in  1  retire head entry (ignored when IRValid=0)
- Level  out  $clog2(DEPTH+1)  number of queued complete instructions
- Overrun  out  1  sticky protocol-violation flag (only with IR_OVERRUN_EN)

## Operation
- Assembly register asm[IR_W-1:0] and lane counter cnt (0..INSTR_BYTES-1).
- cnt==0 is the EMPTY state; cnt>0 is the PARTIAL state.
- Accepted beat writes asm lane cnt, i.e. bits [cnt*BUS_W +: BUS_W]. The first beat is the least-significant lane.
- cnt increments on each accept. On the accept with cnt==INSTR_BYTES-1, {I, asm lower lanes} is pushed to the queue and cnt wraps to 0.
- IReady = !Flush && (cnt != INSTR_BYTES-1 || Level != DEPTH). There is no pop-through: a same-cycle Advance does not raise IReady.
- Queue is a circular FIFO. IROut = head entry and IRValid = (Level != 0).
- Advance with IRValid=1 pops the head.
- Simultaneous push and pop: Level unchanged, head moves to the next entry.
- Flush has priority over everything. On Flush: Level←0, cnt←0, read/write pointers←0, and accept/push/pop in that cycle are suppressed. Queue storage is not cleared, but IROut is forced to 0 whenever IRValid=0.
- INSTR_BYTES=1: every accept pushes directly and the PARTIAL state does not exist.

## Timing
- Reset (async assert, synchronous-safe deassert is the integrator's job): IROut=0, IRValid=0, Level=0, cnt=0, Overrun=0. IReady=1 after reset.
- Reset asserted mid-instruction discards the partial instruction and all queued entries immediately.
- Latency: the last beat accepted at edge k gives IRValid=1 and IROut valid from edge k onward (visible cycle k+1) when the queue was empty.
- Advance at edge k exposes the next head from edge k.
- IReady depends combinationally only on Flush and registered state, never on IValid or Advance.
- Level saturates logically at DEPTH. A push when full is impossible by construction of IReady.

## Configuration
- IR_OVERRUN_EN defined: the Overrun port exists. It is set on the edge where IValid=1 && IReady=0 && !Flush, stays set, and is cleared only by Reset_n or Flush. The rejected beat is dropped.
- Not defined: the Overrun port and its logic are absent. IValid while not ready is silently held off; the producer must keep the beat until accepted.

## Structure
- Package ir_pkg: default BUS_W/INSTR_BYTES/DEPTH constants, and a function returning the lane-counter width max(1,$clog2(INSTR_BYTES)).
- Sub-module ir_queue: parametrised IR_W × DEPTH circular FIFO with push/pop/flush, a level output, and a zero-forced empty output. The top level holds the assembly FSM, handshake and overrun logic.

## Test plan
(BUS_W=8, INSTR_BYTES=2, DEPTH=2 unless noted)
- Reset with Reset_n low mid-stream → IROut=0x0000, IRValid=0, Level=0, IReady=1, Overrun=0 immediately.
- Beats 0x34 then 0x12 → after the second edge IROut=0x1234, IRValid=1, Level=1.
- Push 0x1234 and 0x5678 with no Advance, then beat 0x9A → accepted (cnt=1). IReady then drops; beat 0xBC is held until Advance, after which IROut=0x5678 and 0xBC9A enters the queue (Level=2).
- Level=1 with the last beat 0x22 (after 0x11) and Advance on the same edge → Level stays 1, IROut=0x2211.
- Beat 0xAA accepted, then Flush with IValid=1 → Level=0, IRValid=0. Next beats 0x11, 0x22 → IROut=0x2211, with 0xAA gone.
- IR_OVERRUN_EN, queue full with cnt=1, IValid=1 for one cycle → Overrun=1 and stays 1 until Flush. INSTR_BYTES=4 run: 0x01,0x02,0x03,0x04 → IROut=0x04030201.
